alu32_sched: RTL and testbench
==============================

# alu32_sched

Round-robin scheduler that shares one `alu32` instance between two requesters. It sequences 32-bit operations in one ALU pass and optional 64-bit operations in two passes. In the 64-bit case the low-half carry-out is chained into the high-half carry-in. The block sits between the requesting engines and the combinational `alu32` datapath: it drives the ALU operand/control inputs and captures its outputs.

## Interface
- `WIDE_EN`, default 1: 1 enables two-pass 64-bit ops; 0 treats every request as narrow.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when `valid & ready`.
- `reqK_a`, `reqK_b`  in  64  operands (bits 63:32 used only when wide).
- `reqK_sel`  in  4  74181 function select.
- `reqK_mode`  in  1  74181 mode.
- `reqK_cin`  in  1  carry-in for the first pass.
- `reqK_wide`  in  1  1 = 64-bit two-pass op.
- `alu_a`, `alu_b`  out  32  to `alu32.a/.b`.
- `alu_sel`  out  4  to `alu32.sel`.
- `alu_mode`  out  1  to `alu32.mode`.
- `alu_cin`  out  1  to `alu32.Cin`.
- `alu_result`  in  32  from `alu32.result`.
- `alu_cout`  in  1  from `alu32.Cout`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester index (0/1).
- `rsp_wide`  out  1  echo of the accepted op's wide flag.
- `rsp_result`  out  64  result; bits 63:32 are zero for narrow ops.
- `rsp_cout`  out  1  carry-out of the final pass.

## Operation
- FSM states: IDLE, LO, HI, RESP.
- IDLE:
  - Arbitrate between the two requesters.
  - On `valid & ready`, latch a, b, sel, mode, cin, wide (wide forced 0 when `WIDE_EN=0`) and the id, then go to LO.
- Arbitration:
  - One-bit `last` pointer. If only one requester is valid, it wins. If both are valid, the requester ≠ `last` wins.
  - `last` updates to the winner on accept.
  - Reset value of `last` is 1, so req0 wins the first tie.
- Ready signals:
  - `reqK_ready` = (state==IDLE) & grant==K & !rst. It is combinational from registered state and both valids.
  - Ready is never asserted for both requesters in the same cycle.
- LO:
  - Drive alu_a/b = operand[31:0], alu_cin = latched cin, alu_sel/alu_mode = latched values.
  - At the clock edge, capture alu_result into result[31:0] and alu_cout into a carry register.
  - Next state: HI if wide, else RESP.
- HI:
  - Drive alu_a/b = operand[63:32], alu_cin = carry captured in LO. The carry is passed through unmodified; the 74181 carry polarity is preserved.
  - Capture alu_result into result[63:32] and alu_cout into the carry register, then go to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_result`, `rsp_cout`, `rsp_id` and `rsp_wide` are registered and held stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`, go to IDLE.
- ALU outputs are driven from the operand registers in every state. In IDLE and RESP they hold their last values and are don't-care to the consumer.
- In logic mode (mode=1) carry is still chained and reported, with no special-casing.

## Timing
- Accept at cycle T.
  - Narrow op: LO at T+1, `rsp_valid` rises at T+2.
  - Wide op: LO at T+1, HI at T+2, `rsp_valid` rises at T+3.
- If `rsp_ready` is high during the first RESP cycle, the block is back in IDLE the next cycle. The earliest next accept is that IDLE cycle.
- Peak throughput: one narrow op per 3 cycles, one wide op per 4 cycles.
- Back-pressure: RESP holds indefinitely, and both `reqK_ready` stay 0 meanwhile.
- A requester dropping valid before accept is legal. No state changes in that case.
- Reset:
  - When `rst` is sampled high, the next state is IDLE, `last`=1, `rsp_valid`=0, and all operand, result and carry registers are 0.
  - An in-flight op is discarded with no response. `reqK_ready`=0 in any cycle with `rst` high.
- Reset values of outputs: `rsp_valid`=0, `rsp_id`=0, `rsp_wide`=0, `rsp_result`=0, `rsp_cout`=0, `alu_*`=0, `reqK_ready`=0.

## Test plan
- Narrow pass-through:
  - Stimulus: req0 with a=0x0000_0000_1234_5678, sel=4'b1111, mode=1, wide=0.
  - Expect: `rsp_valid` at T+2, `rsp_result`=0x0000_0000_1234_5678, `rsp_id`=0.
- Wide pass-through:
  - Stimulus: req1 with a=0xDEAD_BEEF_CAFE_F00D, sel=4'b1111, mode=1, wide=1.
  - Expect: `rsp_valid` at T+3, `rsp_result`=0xDEAD_BEEF_CAFE_F00D, `rsp_wide`=1, `rsp_id`=1.
- Carry chaining:
  - Stimulus: wide arithmetic op, a=0x0000_0000_FFFF_FFFF, b=0x0000_0000_0000_0001, sel=4'b1001, mode=0.
  - Expect: `alu_cin` during HI equals `alu_cout` sampled at the end of LO, and `rsp_result` matches a 64-bit `alu32` reference model.
- Round-robin:
  - Stimulus: both valid continuously after reset.
  - Expect: grants ordered 0,1,0,1; `req0_ready` and `req1_ready` never high together.
- Back-pressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles in RESP.
  - Expect: `rsp_*` stable, both readies 0; IDLE one cycle after `rsp_ready`=1.
- Reset mid-op:
  - Stimulus: assert `rst` during HI of a wide op.
  - Expect: next cycle IDLE, `rsp_valid`=0, all outputs at reset values, and no response is ever produced for that op.

Source files
------------

// File: rtl/alu32_sched.sv
// alu32_sched: round-robin front end that shares one combinational alu32
// between two requesters. Narrow (32-bit) ops take one ALU pass; wide
// (64-bit) ops take two passes, and the low-half Cout is fed unchanged into
// the high-half Cin, so the 74181 carry polarity is kept.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqK_valid / reqK_ready     request handshake for requester K (K = 0, 1)
//   reqK_a, reqK_b              64-bit operands (upper half used only when wide)
//   reqK_sel, reqK_mode         74181 function select and mode
//   reqK_cin, reqK_wide         first-pass carry-in, two-pass (64-bit) flag
//   alu_a/b/sel/mode/cin        registered drive into the shared alu32
//   alu_result, alu_cout        combinational return from the alu32
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_wide            winner index and echoed wide flag
//   rsp_result, rsp_cout        64-bit result (upper half 0 when narrow), final carry
module alu32_sched #(
    parameter bit WIDE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [3:0]  req0_sel,
    input  logic        req0_mode,
    input  logic        req0_cin,
    input  logic        req0_wide,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic [3:0]  req1_sel,
    input  logic        req1_mode,
    input  logic        req1_cin,
    input  logic        req1_wide,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    output logic        alu_mode,
    output logic        alu_cin,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_wide,
    output logic [63:0] rsp_result,
    output logic        rsp_cout
);

    localparam int unsigned HW = 32;
    localparam int unsigned FW = 64;
    localparam int unsigned SW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]    state_q,     state_d;
    logic          last_q,      last_d;
    logic          id_q,        id_d;
    logic          wide_q,      wide_d;
    logic [HW-1:0] a_hi_q,      a_hi_d;
    logic [HW-1:0] b_hi_q,      b_hi_d;
    logic [HW-1:0] alu_a_q,     alu_a_d;
    logic [HW-1:0] alu_b_q,     alu_b_d;
    logic [SW-1:0] alu_sel_q,   alu_sel_d;
    logic          alu_mode_q,  alu_mode_d;
    logic          alu_cin_q,   alu_cin_d;
    logic [FW-1:0] result_q,    result_d;
    logic          carry_q,     carry_d;
    logic          rsp_valid_q, rsp_valid_d;

    // Arbitration: a lone requester wins; on a tie the one that did not win last.
    logic grant0_c;
    logic grant1_c;
    logic idle_c;
    logic accept_c;
    logic win_c;

    assign idle_c   = (state_q == S_IDLE);
    assign grant0_c = req0_valid & (~req1_valid | last_q);
    assign grant1_c = req1_valid & (~req0_valid | ~last_q);

    assign req0_ready = idle_c & grant0_c & ~rst;
    assign req1_ready = idle_c & grant1_c & ~rst;
    assign accept_c   = req0_ready | req1_ready;
    assign win_c      = req1_ready;

    // Winner's payload.
    logic [FW-1:0] win_a_c;
    logic [FW-1:0] win_b_c;
    logic [SW-1:0] win_sel_c;
    logic          win_mode_c;
    logic          win_cin_c;
    logic          win_wide_c;

    assign win_a_c    = win_c ? req1_a    : req0_a;
    assign win_b_c    = win_c ? req1_b    : req0_b;
    assign win_sel_c  = win_c ? req1_sel  : req0_sel;
    assign win_mode_c = win_c ? req1_mode : req0_mode;
    assign win_cin_c  = win_c ? req1_cin  : req0_cin;
    assign win_wide_c = (win_c ? req1_wide : req0_wide) & WIDE_EN;

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        wide_d      = wide_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        alu_mode_d  = alu_mode_q;
        alu_cin_d   = alu_cin_q;
        result_d    = result_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    last_d     = win_c;
                    id_d       = win_c;
                    wide_d     = win_wide_c;
                    alu_a_d    = win_a_c[HW-1:0];
                    alu_b_d    = win_b_c[HW-1:0];
                    a_hi_d     = win_a_c[FW-1:HW];
                    b_hi_d     = win_b_c[FW-1:HW];
                    alu_sel_d  = win_sel_c;
                    alu_mode_d = win_mode_c;
                    alu_cin_d  = win_cin_c;
                    // Clearing here leaves the upper half zero for narrow ops.
                    result_d   = '0;
                    state_d    = S_LO;
                end
            end
            S_LO: begin
                result_d = {result_q[FW-1:HW], alu_result};
                carry_d  = alu_cout;
                if (wide_q) begin
                    // Present the high halves with the low-half Cout as Cin.
                    alu_a_d   = a_hi_q;
                    alu_b_d   = b_hi_q;
                    alu_cin_d = alu_cout;
                    state_d   = S_HI;
                end else begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_HI: begin
                result_d    = {alu_result, result_q[HW-1:0]};
                carry_d     = alu_cout;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            wide_q      <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_mode_q  <= 1'b0;
            alu_cin_q   <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            wide_q      <= wide_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            alu_mode_q  <= alu_mode_d;
            alu_cin_q   <= alu_cin_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign alu_mode   = alu_mode_q;
    assign alu_cin    = alu_cin_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_wide   = wide_q;
    assign rsp_result = result_q;
    assign rsp_cout   = carry_q;

endmodule

// File: tb/tb_alu32_sched.sv
// Bench for alu32_sched: a behavioural 74181-style alu32 closes the ALU loop,
// and results are compared with the same function evaluated at full 64 bits.
module tb_alu32_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_mode, req0_cin, req0_wide;
    logic [63:0] req0_a, req0_b;
    logic [3:0]  req0_sel;
    logic        req1_valid, req1_ready, req1_mode, req1_cin, req1_wide;
    logic [63:0] req1_a, req1_b;
    logic [3:0]  req1_sel;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    logic        alu_mode, alu_cin, alu_cout;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_wide, rsp_cout;
    logic [63:0] rsp_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu32_sched #(.WIDE_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .req0_mode(req0_mode), .req0_cin(req0_cin), .req0_wide(req0_wide),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .req1_mode(req1_mode), .req1_cin(req1_cin), .req1_wide(req1_wide),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_mode(alu_mode), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_wide(rsp_wide),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout)
    );

    // 74181 semantics (active-high data, active-low carries) at width w (32 or 64).
    // Returns {Cout, F}.
    function automatic logic [64:0] f181(input logic [63:0] a, input logic [63:0] b,
                                         input logic [3:0] s, input logic m,
                                         input logic cin, input int w);
        logic [63:0] mask, x, y, f;
        logic [64:0] sum;
        logic        carry;
        mask  = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        x     = (a | (b & {64{s[0]}}) | (~b & {64{s[1]}})) & mask;
        y     = ((a & ~b & {64{s[2]}}) | (a & b & {64{s[3]}})) & mask;
        sum   = {1'b0, x} + {1'b0, y} + 65'(!cin);
        carry = (w == 64) ? sum[64] : sum[32];
        if (!m) begin
            f = sum[63:0];
        end else begin
            case (s)
                4'h0: f = ~a;
                4'h1: f = ~(a | b);
                4'h2: f = ~a & b;
                4'h3: f = '0;
                4'h4: f = ~(a & b);
                4'h5: f = ~b;
                4'h6: f = a ^ b;
                4'h7: f = a & ~b;
                4'h8: f = ~a | b;
                4'h9: f = ~(a ^ b);
                4'hA: f = b;
                4'hB: f = a & b;
                4'hC: f = '1;
                4'hD: f = a | ~b;
                4'hE: f = a | b;
                default: f = a;
            endcase
        end
        return {~carry, f & mask};
    endfunction

    // The shared combinational alu32 the scheduler drives.
    logic [64:0] alu_out;
    assign alu_out    = f181({32'h0, alu_a}, {32'h0, alu_b}, alu_sel, alu_mode, alu_cin, 32);
    assign alu_result = alu_out[31:0];
    assign alu_cout   = alu_out[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] sel, input logic mode, input logic cin,
                         input logic wide);
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_sel = sel; req0_mode = mode;
            req0_cin = cin; req0_wide = wide; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sel = sel; req1_mode = mode;
            req1_cin = cin; req1_wide = wide; req1_valid = 1'b1;
        end
    endtask

    // Issue one op from a single requester, check per-pass ALU drive, latency,
    // the response, holding under `stall` cycles of back-pressure, and release.
    task automatic run_op(input logic id, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] sel, input logic mode, input logic cin,
                          input logic wide, input logic [63:0] exp_res, input logic exp_cout,
                          input int stall, input string name);
        logic got;
        logic lo_cout;
        int   lat;
        @(negedge clk);
        drive(id, a, b, sel, mode, cin, wide);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) got = 1'b1;
            else @(negedge clk);
        end
        chk({name, "/accept"}, 64'(got), 64'd1);
        if (!got) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        lat = 0; lo_cout = 1'b0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk({name, "/lo_a"}, 64'(alu_a), 64'(a[31:0]));
                chk({name, "/lo_cin"}, 64'(alu_cin), 64'(cin));
                lo_cout = alu_cout;
            end
            if (n == 2 && wide) begin
                chk({name, "/hi_a"}, 64'(alu_a), 64'(a[63:32]));
                chk({name, "/hi_b"}, 64'(alu_b), 64'(b[63:32]));
                chk({name, "/hi_cin"}, 64'(alu_cin), 64'(lo_cout));
            end
            if (rsp_valid) lat = n;
        end
        chk({name, "/latency"}, 64'(lat), wide ? 64'd3 : 64'd2);
        if (lat == 0) return;
        chk({name, "/result"}, rsp_result, exp_res);
        chk({name, "/cout"}, 64'(rsp_cout), 64'(exp_cout));
        chk({name, "/id"}, 64'(rsp_id), 64'(id));
        chk({name, "/wide"}, 64'(rsp_wide), 64'(wide));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({name, "/hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({name, "/hold_result"}, rsp_result, exp_res);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({name, "/released"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "/rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({name, "/rsp_id"}, 64'(rsp_id), 64'd0);
        chk({name, "/rsp_wide"}, 64'(rsp_wide), 64'd0);
        chk({name, "/rsp_result"}, rsp_result, 64'd0);
        chk({name, "/rsp_cout"}, 64'(rsp_cout), 64'd0);
        chk({name, "/alu_a"}, 64'(alu_a), 64'd0);
        chk({name, "/alu_b"}, 64'(alu_b), 64'd0);
        chk({name, "/alu_sel"}, 64'(alu_sel), 64'd0);
        chk({name, "/alu_mode"}, 64'(alu_mode), 64'd0);
        chk({name, "/alu_cin"}, 64'(alu_cin), 64'd0);
    endtask

    typedef struct {
        logic        id;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  sel;
        logic        mode;
        logic        cin;
        logic        wide;
        logic [63:0] exp_res;
        logic        exp_cout;
    } vec_t;

    vec_t vt[7];
    int   grants[$];
    int   gcyc[$];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb;
        logic [3:0]  rs;
        logic        rm, rc, rw, rid;
        logic [64:0] ref_out;
        int          seen;

        // pass-through, wide pass-through, carry chain, add, subtract w/ carry, wide xor, narrow ignores upper bits
        vt[0] = '{1'b0, 64'h0000_0000_1234_5678, 64'h0, 4'hF, 1'b1, 1'b1, 1'b0, 64'h0000_0000_1234_5678, 1'b0};
        vt[1] = '{1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 4'hF, 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
        vt[2] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 4'h9, 1'b0, 1'b1, 1'b1, 64'h0000_0001_0000_0000, 1'b1};
        vt[3] = '{1'b1, 64'h5, 64'h3, 4'h9, 1'b0, 1'b1, 1'b0, 64'h8, 1'b1};
        vt[4] = '{1'b0, 64'hA, 64'h3, 4'h6, 1'b0, 1'b0, 1'b0, 64'h7, 1'b0};
        vt[5] = '{1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'h6, 1'b1, 1'b1, 1'b1,
                  64'h0FF0_0FF0_0FF0_0FF0, 1'b1};
        vt[6] = '{1'b0, 64'hFFFF_0000_0000_0001, 64'h0, 4'hF, 1'b1, 1'b1, 1'b0, 64'h1, 1'b0};

        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_sel = '0; req0_mode = 1'b0; req0_cin = 1'b0; req0_wide = 1'b0;
        req1_a = '0; req1_b = '0; req1_sel = '0; req1_mode = 1'b0; req1_cin = 1'b0; req1_wide = 1'b0;

        // Reset state; readies stay low while rst is high even with both valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst/req0_ready", 64'(req0_ready), 64'd0);
        chk("rst/req1_ready", 64'(req1_ready), 64'd0);
        check_reset_outputs("rst");
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        foreach (vt[i])
            run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].sel, vt[i].mode, vt[i].cin, vt[i].wide,
                   vt[i].exp_res, vt[i].exp_cout, i % 3, $sformatf("vec%0d", i));

        // Back-pressure: RESP held for 5 cycles with both requesters waiting.
        @(negedge clk);
        drive(1'b0, 64'h0000_0000_AAAA_5555, 64'h0, 4'hF, 1'b1, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            #1;
            if (req0_ready) seen = 1;
            else @(negedge clk);
        end
        chk("bp/accept", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        req1_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("bp/rsp_valid", 64'(seen), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp/hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp/hold_result", rsp_result, 64'h0000_0000_AAAA_5555);
            chk("bp/hold_id", 64'(rsp_id), 64'd0);
            chk("bp/hold_wide", 64'(rsp_wide), 64'd0);
            chk("bp/hold_cout", 64'(rsp_cout), 64'd0);
            chk("bp/readies", 64'({req0_ready, req1_ready}), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp/after_valid", 64'(rsp_valid), 64'd0);
        chk("bp/idle_grant1", 64'({req0_ready, req1_ready}), 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Round-robin from reset with both requesters continuously valid.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1;
        drive(1'b0, 64'h11, 64'h0, 4'hF, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 64'h22, 64'h0, 4'hF, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("rr/exclusive", 64'(req0_ready & req1_ready), 64'd0);
            if (req0_ready) begin grants.push_back(0); gcyc.push_back(c); end
            else if (req1_ready) begin grants.push_back(1); gcyc.push_back(c); end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (5) @(negedge clk);
        rsp_ready = 1'b0;
        chk("rr/count", 64'(grants.size() >= 4), 64'd1);
        if (grants.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("rr/grant%0d", i), 64'(grants[i]), 64'(i % 2));
            for (int i = 1; i < 4; i++) chk($sformatf("rr/gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'd3);
        end

        // Reset during the HI pass of a wide op.
        @(negedge clk);
        drive(1'b1, 64'h1234_5678_FFFF_FFFF, 64'h0000_0001_0000_0001, 4'h9, 1'b0, 1'b1, 1'b1);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            #1;
            if (req1_ready) seen = 1;
            else @(negedge clk);
        end
        chk("rmid/accept", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rmid/in_hi", 64'(alu_a), 64'h1234_5678);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rmid");
        req0_valid = 1'b1;
        #1;
        chk("rmid/idle", 64'(req0_ready), 64'd1);
        req0_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rmid/no_rsp", 64'(seen), 64'd0);

        // Randomized ops against the 64-bit reference.
        for (int k = 0; k < 150; k++) begin
            rid = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rs  = 4'($urandom_range(0, 15));
            rm  = 1'($urandom_range(0, 1));
            rc  = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            ref_out = f181(ra, rb, rs, rm, rc, rw ? 64 : 32);
            run_op(rid, ra, rb, rs, rm, rc, rw, ref_out[63:0], ref_out[64],
                   $urandom_range(0, 2), $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
